// File: rtl/br_resolve_unit.sv
// rtl/br_resolve_unit.sv - EX-stage branch resolver: registered flush/redirect, BTB write queue, perf counters
module br_resolve_unit #(
   parameter int IDX_W  = 9,
   parameter int QDEPTH = 2,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_EX,
   input  logic                 stall_EX,
   input  logic                 br_instr_EX,
   input  logic                 br_taken_EX,
   input  logic [15:0]          pc_EX,
   input  logic [15:0]          dst_EX,
   input  logic                 pred_hit_EX,
   input  logic [15:0]          pred_tgt_EX,
   input  logic                 pred_strong_EX,
   input  logic                 btb_wr_rdy,
   output logic                 flush,
   output logic [15:0]          redirect_PC,
   output logic                 btb_wr_en,
   output logic [IDX_W-1:0]     btb_wr_index,
   output logic [33-IDX_W:0]    btb_wr_data,
   output logic                 wr_drop,
   output logic [CNT_W-1:0]     br_cnt,
   output logic [CNT_W-1:0]     mispred_cnt
);

   localparam int TAG_W = 16 - IDX_W;
   localparam int DW    = TAG_W + 18;
   localparam int EW    = IDX_W + DW;
   localparam int AW    = $clog2(QDEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [EW-1:0]    r_mem [QDEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;

   logic             w_ev;
   logic             w_mispred;
   logic             w_push;
   logic [15:0]      w_redirect;
   logic [DW-1:0]    w_wdata;
   logic [TAG_W-1:0] w_tag;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_wr;
   logic [EW-1:0]    w_head;

   // The instruction sitting in EX during a flush cycle is wrong-path.
   assign w_ev  = valid_EX & ~stall_EX & br_instr_EX & ~flush;
   assign w_tag = pc_EX[15:IDX_W];

   always_comb begin
      w_mispred  = 1'b0;
      w_push     = 1'b0;
      w_redirect = dst_EX;
      w_wdata    = '0;
      if (br_taken_EX) begin
         if (!pred_hit_EX || (pred_tgt_EX != dst_EX)) begin
            w_mispred = 1'b1;
            w_push    = 1'b1;
            w_wdata   = {w_tag, 1'b0, 1'b1, dst_EX};
         end else if (!pred_strong_EX) begin
            w_push  = 1'b1;
            w_wdata = {w_tag, 1'b1, 1'b1, dst_EX};
         end
      end else if (pred_hit_EX) begin
         w_mispred  = 1'b1;
         w_push     = 1'b1;
         w_redirect = pc_EX + 16'd1;
         // A weak entry that mispredicts not-taken is evicted outright.
         w_wdata    = pred_strong_EX ? {w_tag, 1'b0, 1'b1, pred_tgt_EX} : '0;
      end
   end

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign w_pop   = ~w_empty & btb_wr_rdy;
   assign w_wr    = w_ev & w_push & (~w_full | w_pop);
   assign w_head  = r_mem[r_rptr[AW-1:0]];

   assign btb_wr_en    = ~w_empty;
   assign btb_wr_index = w_empty ? '0 : w_head[EW-1:DW];
   assign btb_wr_data  = w_empty ? '0 : w_head[DW-1:0];

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= {pc_EX[IDX_W-1:0], w_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         flush       <= 1'b0;
         redirect_PC <= '0;
         wr_drop     <= 1'b0;
         br_cnt      <= '0;
         mispred_cnt <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + PTR_ONE;
         if (w_pop) r_rptr <= r_rptr + PTR_ONE;
         flush   <= w_ev & w_mispred;
         wr_drop <= w_ev & w_push & w_full & ~w_pop;
         if (w_ev && w_mispred) redirect_PC <= w_redirect;
         if (w_ev && !(&br_cnt)) br_cnt <= br_cnt + CNT_ONE;
         if (w_ev && w_mispred && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_br_resolve_unit.sv
// tb/tb_br_resolve_unit.sv - scoreboard bench for br_resolve_unit
module tb_br_resolve_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid_EX, stall_EX, br_instr_EX, br_taken_EX;
   logic        pred_hit_EX, pred_strong_EX, btb_wr_rdy;
   logic [15:0] pc_EX, dst_EX, pred_tgt_EX;

   logic        flush, btb_wr_en, wr_drop;
   logic [15:0] redirect_PC;
   logic [8:0]  btb_wr_index;
   logic [24:0] btb_wr_data;
   logic [15:0] br_cnt, mispred_cnt;

   logic        flush_s, btb_wr_en_s, wr_drop_s;
   logic [15:0] redirect_PC_s;
   logic [8:0]  btb_wr_index_s;
   logic [24:0] btb_wr_data_s;
   logic [1:0]  br_cnt_s, mispred_cnt_s;

   br_resolve_unit #(.IDX_W(9), .QDEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .valid_EX(valid_EX), .stall_EX(stall_EX),
      .br_instr_EX(br_instr_EX), .br_taken_EX(br_taken_EX), .pc_EX(pc_EX),
      .dst_EX(dst_EX), .pred_hit_EX(pred_hit_EX), .pred_tgt_EX(pred_tgt_EX),
      .pred_strong_EX(pred_strong_EX), .btb_wr_rdy(btb_wr_rdy),
      .flush(flush), .redirect_PC(redirect_PC), .btb_wr_en(btb_wr_en),
      .btb_wr_index(btb_wr_index), .btb_wr_data(btb_wr_data), .wr_drop(wr_drop),
      .br_cnt(br_cnt), .mispred_cnt(mispred_cnt));

   br_resolve_unit #(.IDX_W(9), .QDEPTH(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .valid_EX(valid_EX), .stall_EX(stall_EX),
      .br_instr_EX(br_instr_EX), .br_taken_EX(br_taken_EX), .pc_EX(pc_EX),
      .dst_EX(dst_EX), .pred_hit_EX(pred_hit_EX), .pred_tgt_EX(pred_tgt_EX),
      .pred_strong_EX(pred_strong_EX), .btb_wr_rdy(btb_wr_rdy),
      .flush(flush_s), .redirect_PC(redirect_PC_s), .btb_wr_en(btb_wr_en_s),
      .btb_wr_index(btb_wr_index_s), .btb_wr_data(btb_wr_data_s), .wr_drop(wr_drop_s),
      .br_cnt(br_cnt_s), .mispred_cnt(mispred_cnt_s));

   int checks = 0;
   int errors = 0;
   logic [15:0] q_redir[$];
   logic [33:0] q_wr[$];
   int m_br, m_mis;

   task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: consumes expectations whenever the DUT shows a flush or a write.
   initial begin
      logic [15:0] er;
      logic [33:0] ew;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (flush) begin
               if (q_redir.size() == 0) chk("unexpected_flush", {18'h0, redirect_PC}, 34'h3FFFFFFFF);
               else begin er = q_redir.pop_front(); chk("redirect_PC", {18'h0, redirect_PC}, {18'h0, er}); end
            end
            if (btb_wr_en && btb_wr_rdy) begin
               if (q_wr.size() == 0) chk("unexpected_write", {btb_wr_index, btb_wr_data}, 34'h3FFFFFFFF);
               else begin ew = q_wr.pop_front(); chk("btb_write", {btb_wr_index, btb_wr_data}, ew); end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      valid_EX = 1'b0; stall_EX = 1'b0; br_instr_EX = 1'b0; br_taken_EX = 1'b0;
      pred_hit_EX = 1'b0; pred_strong_EX = 1'b0;
   endtask

   task automatic drive(input logic stl, input logic tk, input logic [15:0] pc, input logic [15:0] dst,
                        input logic hit, input logic [15:0] tgt, input logic s);
      valid_EX = 1'b1; br_instr_EX = 1'b1; stall_EX = stl; br_taken_EX = tk;
      pc_EX = pc; dst_EX = dst; pred_hit_EX = hit; pred_tgt_EX = tgt; pred_strong_EX = s;
      @(posedge clk); #1;
      idle();
   endtask

   task automatic br(input logic tk, input logic [15:0] pc, input logic [15:0] dst, input logic hit,
                     input logic [15:0] tgt, input logic s, input logic mis, input logic [15:0] redir,
                     input logic push, input logic [8:0] idx, input logic [24:0] data);
      if (mis) q_redir.push_back(redir);
      if (push) q_wr.push_back({idx, data});
      m_br++;
      if (mis) m_mis++;
      drive(1'b0, tk, pc, dst, hit, tgt, s);
   endtask

   task automatic wrong_path();
      drive(1'b0, 1'b1, 16'h7777, 16'h0666, 1'b0, 16'h0000, 1'b0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (q_wr.size() != 0 || q_redir.size() != 0); i++) step();
      chk("drain_wr", 34'(q_wr.size()), 34'd0);
      chk("drain_flush", 34'(q_redir.size()), 34'd0);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      step();
      rst = 1'b0;
      q_wr.delete();
      q_redir.delete();
      m_br = 0;
      m_mis = 0;
   endtask

   task automatic chk_cnt();
      chk("br_cnt", {18'h0, br_cnt}, 34'(m_br));
      chk("mispred_cnt", {18'h0, mispred_cnt}, 34'(m_mis));
   endtask

   initial begin
      idle();
      pc_EX = '0; dst_EX = '0; pred_tgt_EX = '0;
      btb_wr_rdy = 1'b1;
      rst = 1'b1;
      step();
      reset_dut();
      chk("rst_flush", {33'h0, flush}, 34'd0);
      chk("rst_redirect", {18'h0, redirect_PC}, 34'd0);
      chk("rst_wr_en", {33'h0, btb_wr_en}, 34'd0);
      chk("rst_wr_idx_data", {btb_wr_index, btb_wr_data}, 34'd0);
      chk("rst_wr_drop", {33'h0, wr_drop}, 34'd0);
      chk_cnt();

      // taken, BTB miss: allocate
      br(1'b1, 16'h0203, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b1, 9'h003, 25'h0050100);
      step();
      drain();

      reset_dut();
      // correct weak hit strengthens; correct strong hit does nothing
      br(1'b1, 16'h0203, 16'h0100, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h003, 25'h0070100);
      br(1'b1, 16'h0203, 16'h0100, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 25'h0);
      drain();
      chk("br_cnt_t2", {18'h0, br_cnt}, 34'd2);
      chk_cnt();

      // not taken weak hit at top of PC space: evict, redirect wraps
      br(1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 9'h1FF, 25'h0);
      step();
      drain();
      chk_cnt();

      // queue fills with write port stalled; third update dropped, wrong-path ignored
      btb_wr_rdy = 1'b0;
      br(1'b1, 16'h0400, 16'h0500, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0500, 1'b1, 9'h000, 25'h0090500);
      wrong_path();
      br(1'b0, 16'h0A11, 16'h0000, 1'b1, 16'h0222, 1'b1, 1'b1, 16'h0A12, 1'b1, 9'h011, 25'h0150222);
      wrong_path();
      br(1'b1, 16'h1234, 16'h0033, 1'b1, 16'h0044, 1'b0, 1'b1, 16'h0033, 1'b0, 9'h000, 25'h0);
      chk("wr_drop_pulse", {33'h0, wr_drop}, 34'd1);
      chk("wr_en_full", {33'h0, btb_wr_en}, 34'd1);
      step();
      chk("wr_drop_clear", {33'h0, wr_drop}, 34'd0);
      btb_wr_rdy = 1'b1;
      drain();
      chk_cnt();

      // stalled mispredict has no effect
      drive(1'b1, 1'b1, 16'h0300, 16'h0400, 1'b0, 16'h0000, 1'b0);
      chk("stall_flush", {33'h0, flush}, 34'd0);
      chk("stall_wr_en", {33'h0, btb_wr_en}, 34'd0);
      step();
      chk_cnt();

      // counter saturation (2-bit instance) and reset with queue non-empty
      reset_dut();
      btb_wr_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         br(1'b1, 16'h0100 + 16'(i), 16'h0800 + 16'(i), 1'b0, 16'h0000, 1'b0,
            1'b1, 16'h0800 + 16'(i), (i < 2), 9'h100 + 9'(i), 25'h0010800 + 25'(i));
         if (i == 1) chk("sat_mispred_pre", {32'h0, mispred_cnt_s}, 34'd2);
         step();
      end
      chk("sat_mispred", {32'h0, mispred_cnt_s}, 34'd3);
      chk("sat_br", {32'h0, br_cnt_s}, 34'd3);
      chk_cnt();
      chk("wr_en_before_rst", {33'h0, btb_wr_en}, 34'd1);
      chk("flush_drained", 34'(q_redir.size()), 34'd0);
      reset_dut();
      chk("rst_mid_wr_en", {33'h0, btb_wr_en}, 34'd0);
      chk_cnt();
      chk("rst_mid_sat", {30'h0, br_cnt_s, mispred_cnt_s}, 34'd0);
      btb_wr_rdy = 1'b1;
      repeat (3) step();
      chk("post_rst_wr_en", {33'h0, btb_wr_en}, 34'd0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
